// File: rtl/cpu_pkg.sv
// cpu_pkg: types and default widths shared by the fetch path.
//   CPU_ADDR_W  - default program-counter width
//   CPU_INSTR_W - default instruction width
//   fq_entry_t  - one fetch-queue entry: {instr, pc}
package cpu_pkg;

  localparam int CPU_ADDR_W  = 64;
  localparam int CPU_INSTR_W = 32;

  typedef struct packed {
    logic [CPU_INSTR_W-1:0] instr;
    logic [CPU_ADDR_W-1:0]  pc;
  } fq_entry_t;

endpackage

// File: rtl/adder_64bit.sv
// adder_64bit: plain 64-bit modulo-2^64 adder used for program-counter increments.
//   a_i, b_i - operands
//   sum_o    - a_i + b_i, carry out discarded
module adder_64bit (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic [63:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/fq_storage.sv
// fq_storage: DEPTH-entry register file holding fetch-queue entries.
// Synchronous write, asynchronous (zero-latency) read. Contents are not reset.
//   clk     - clock
//   we_i    - write enable
//   waddr_i - write index
//   wdata_i - entry to write
//   raddr_i - read index
//   rdata_o - entry at raddr_i, combinational
module fq_storage
  import cpu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fq_entry_t,
  parameter int  PTR_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  entry_t           wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output entry_t           rdata_o
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch PC generator plus a DEPTH-entry FIFO of
// fetched {instr, pc} pairs feeding decode.
//   clk, reset        - clock, synchronous active-high reset
//   fetch_en          - allow a fetch/enqueue this cycle
//   redirect          - flush queue and restart fetch at redirect_pc
//   redirect_pc       - restart address
//   imem_addr         - current fetch PC to instruction memory
//   imem_instr        - instruction at imem_addr (same cycle)
//   deq_ready         - decode accepts the head entry
//   deq_valid         - head entry is valid
//   deq_instr, deq_pc - head entry contents
//   deq_pc_plus4      - deq_pc + 4
//   count, full, empty- occupancy status
//
// Handshake: an entry leaves the queue on a cycle where deq_valid && deq_ready
// at the rising edge (deq_fire). deq_valid never depends on deq_ready, and
// deq_ready is ignored while deq_valid is low.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int INSTR_W = CPU_INSTR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]       imem_instr,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [INSTR_W-1:0]       deq_instr,
  output logic [ADDR_W-1:0]        deq_pc,
  output logic [ADDR_W-1:0]        deq_pc_plus4,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  // Same layout as fq_entry_t, sized to this instance's widths.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              enq;
  logic              deq_fire;
  logic [ADDR_W-1:0] fetch_pc_plus4;
  logic [ADDR_W-1:0] head_pc_plus4;
  entry_t            wr_entry;
  entry_t            head_entry;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign deq_valid = ~empty & ~redirect;
  assign deq_fire  = deq_valid & deq_ready;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign enq       = fetch_en & ~redirect & (~full | deq_fire);

  generate
    if (ADDR_W == 64) begin : g_add64
      adder_64bit u_fetch_add (
        .a_i   (fetch_pc_q),
        .b_i   (PC_STEP),
        .sum_o (fetch_pc_plus4)
      );
      adder_64bit u_head_add (
        .a_i   (head_entry.pc),
        .b_i   (PC_STEP),
        .sum_o (head_pc_plus4)
      );
    end else begin : g_addn
      assign fetch_pc_plus4 = fetch_pc_q + PC_STEP;
      assign head_pc_plus4  = head_entry.pc + PC_STEP;
    end
  endgenerate

  assign wr_entry.instr = imem_instr;
  assign wr_entry.pc    = fetch_pc_q;

  fq_storage #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_storage (
    .clk     (clk),
    .we_i    (enq & ~reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (enq) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_plus4;
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({enq, deq_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr    = fetch_pc_q;
  assign deq_instr    = head_entry.instr;
  assign deq_pc       = head_entry.pc;
  assign deq_pc_plus4 = head_pc_plus4;
  assign count        = count_q;

endmodule
